// File: rtl/crypto_dispatch_pkg.sv
// Shared types and defaults for the crypto core dispatcher: FSM states, mode encodings,
// default start-pulse and timeout lengths.
package crypto_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;

  localparam int DEF_BGN_CYCLES     = 10;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == MODE_ENC) || (mode == MODE_DEC);
  endfunction

endpackage

// File: rtl/crypto_dispatch_if.sv
// Request/response handshake bundle between a requester and the crypto dispatcher.
// Transfers happen on any rising edge where valid and ready are both high.
interface crypto_dispatch_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [15:0] req_key;
  logic [15:0] req_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [15:0] rsp_key;
  logic [1:0]  rsp_mode;
  logic        rsp_error;

  modport master (
    output req_valid, req_mode, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_key, rsp_mode, rsp_error
  );

  modport slave (
    input  req_valid, req_mode, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_key, rsp_mode, rsp_error
  );
endinterface

// File: rtl/crypto_dispatch_timer.sv
// Cycle counter: load clears, en advances, expire is high during the limit-th counted cycle.
// No backpressure; the count holds once expired until reloaded.
module crypto_dispatch_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  assign expire = (cnt == limit - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/crypto_dispatch.sv
// Dispatches one request at a time to a crypto core; latency 1 + BGN_CYCLES + core time + 1, invalid mode 1.
// req_ready only in IDLE; the response is held until rsp_ready, which stalls new requests.
module crypto_dispatch
  import crypto_dispatch_pkg::*;
#(
  parameter int BGN_CYCLES     = DEF_BGN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  crypto_dispatch_if.slave  bus,
  output logic              core_rst_n,
  output logic              core_bgn,
  output logic [1:0]        core_mode,
  output logic [15:0]       core_key,
  output logic [15:0]       core_data,
  input  logic              core_done_data,
  input  logic              core_done_key,
  input  logic [15:0]       core_data_out,
  input  logic [15:0]       core_key_out,
  output logic [7:0]        op_count
);

  localparam int TMAX = (TIMEOUT_CYCLES > BGN_CYCLES) ? TIMEOUT_CYCLES : BGN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t state, state_nxt;
  logic   flag_data, flag_key;
  logic   done_all;
  logic   bgn_exp, tmo_exp;
  logic   timers_load, bgn_en, tmo_en;

  // A done strobe in the current cycle counts, so completion beats a same-cycle timeout.
  assign done_all    = (flag_data | core_done_data) & (flag_key | core_done_key);
  assign timers_load = (state == ST_CLR);
  assign bgn_en      = (state == ST_START);
  assign tmo_en      = (state == ST_START) || (state == ST_WAIT);

  assign bus.req_ready = (state == ST_IDLE) && !rst;
  assign bus.rsp_valid = (state == ST_RESP);
  assign core_bgn      = (state == ST_START);

  crypto_dispatch_timer #(.WIDTH(TW)) u_bgn_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timers_load),
    .en     (bgn_en),
    .limit  (TW'(BGN_CYCLES)),
    .expire (bgn_exp)
  );

  crypto_dispatch_timer #(.WIDTH(TW)) u_tmo_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timers_load),
    .en     (tmo_en),
    .limit  (TW'(TIMEOUT_CYCLES)),
    .expire (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) state_nxt = mode_valid(bus.req_mode) ? ST_CLR : ST_RESP;
      ST_CLR:   state_nxt = ST_START;
      ST_START: if (bgn_exp) state_nxt = ST_WAIT;
      ST_WAIT:  if (done_all || tmo_exp) state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_n    <= 1'b0;
      core_mode     <= '0;
      core_key      <= '0;
      core_data     <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_key   <= '0;
      bus.rsp_mode  <= '0;
      bus.rsp_error <= 1'b0;
      flag_data     <= 1'b0;
      flag_key      <= 1'b0;
      op_count      <= '0;
    end else begin
      // Registered so the core sees a clean one-cycle low exactly while in CLR.
      core_rst_n <= (state_nxt != ST_CLR);
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            core_mode     <= bus.req_mode;
            core_key      <= bus.req_key;
            core_data     <= bus.req_data;
            bus.rsp_mode  <= bus.req_mode;
            bus.rsp_data  <= '0;
            bus.rsp_key   <= '0;
            bus.rsp_error <= !mode_valid(bus.req_mode);
            flag_data     <= 1'b0;
            flag_key      <= 1'b0;
          end
        end
        ST_START, ST_WAIT: begin
          if (core_done_data) begin
            bus.rsp_data <= core_data_out;
            flag_data    <= 1'b1;
          end
          if (core_done_key) begin
            bus.rsp_key <= core_key_out;
            flag_key    <= 1'b1;
          end
          if ((state == ST_WAIT) && tmo_exp && !done_all) begin
            bus.rsp_error <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) op_count <= op_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
